// File: rtl/add_sub.sv
// WIDTH-bit adder/subtractor sharing one adder for a+b and a-b, with combinational flags
// and a one-cycle registered copy of the result and flags.
module add_sub #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             is_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic [WIDTH-1:0] out_q,
  output logic [3:0]       flags_q
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   sum;

  // Subtraction reuses the adder as a + ~b + 1; carry-out then means "no borrow".
  always_comb begin
    bx       = b ^ {WIDTH{is_sub}};
    sum      = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, is_sub};
    out      = sum[WIDTH-1:0];
    carry    = sum[WIDTH];
    overflow = (a[WIDTH-1] == bx[WIDTH-1]) && (out[WIDTH-1] != a[WIDTH-1]);
    zero     = (out == '0);
    negative = out[WIDTH-1];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_q   <= '0;
      flags_q <= 4'b0000;
    end else begin
      out_q   <= out;
      flags_q <= {carry, overflow, zero, negative};
    end
  end

endmodule

// File: tb/tb_add_sub.sv
// Self-checking bench for add_sub: directed vector table, reset/latency sequences and
// randomized operands checked against an arithmetic reference model.
module tb_add_sub;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        is_sub = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] out;
  logic        carry, overflow, zero, negative;
  logic [31:0] out_q;
  logic [3:0]  flags_q;

  int total = 0;
  int bad = 0;

  add_sub #(.WIDTH(32)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .is_sub   (is_sub),
    .a        (a),
    .b        (b),
    .out      (out),
    .carry    (carry),
    .overflow (overflow),
    .zero     (zero),
    .negative (negative),
    .out_q    (out_q),
    .flags_q  (flags_q)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;
    logic [3:0]  flags;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic, unsigned for carry, signed for overflow.
  function automatic void model(input logic s, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] o, output logic [3:0] f);
    logic [63:0] ux, uy, ur;
    longint      sx, sy, sr;
    logic        c, v;
    ux = {32'b0, x};
    uy = {32'b0, y};
    ur = s ? (ux - uy) : (ux + uy);
    o  = ur[31:0];
    c  = s ? (x >= y) : ur[32];
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sr = s ? (sx - sy) : (sx + sy);
    v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    f  = {c, v, (o == 32'd0), o[31]};
  endfunction

  task automatic check_comb(input string name, input logic [31:0] eo, input logic [3:0] ef);
    check({name, ".out"}, {32'b0, out}, {32'b0, eo});
    check({name, ".flags"}, {60'b0, carry, overflow, zero, negative}, {60'b0, ef});
  endtask

  task automatic check_reg(input string name, input logic [31:0] eo, input logic [3:0] ef);
    check({name, ".out_q"}, {32'b0, out_q}, {32'b0, eo});
    check({name, ".flags_q"}, {60'b0, flags_q}, {60'b0, ef});
  endtask

  initial begin
    logic [31:0] eo;
    logic [3:0]  ef;

    vecs[0] = '{1'b0, 32'd312,        32'd1000,       32'd1312,       4'b0000};
    vecs[1] = '{1'b1, 32'd312,        32'd1000,       32'hFFFFFD50,   4'b0001};
    vecs[2] = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'd0,          4'b1010};
    vecs[3] = '{1'b0, 32'h7FFFFFFF,   32'd1,          32'h80000000,   4'b0101};
    vecs[4] = '{1'b1, 32'h80000000,   32'd1,          32'h7FFFFFFF,   4'b1100};
    vecs[5] = '{1'b1, 32'd5,          32'd5,          32'd0,          4'b1010};
    vecs[6] = '{1'b1, 32'd0,          32'd0,          32'd0,          4'b1010};
    vecs[7] = '{1'b0, 32'd0,          32'd0,          32'd0,          4'b0010};
    vecs[8] = '{1'b1, 32'd0,          32'd1,          32'hFFFFFFFF,   4'b0001};
    vecs[9] = '{1'b0, 32'h80000000,   32'h80000000,   32'd0,          4'b1110};

    // Asynchronous reset between edges clears the registers immediately.
    #2 RST_N = 1'b0;
    #1 check_reg("reset", 32'd0, 4'b0000);

    // Combinational vectors evaluated without any clock dependency.
    for (int i = 0; i < 10; i++) begin
      is_sub = vecs[i].sub;
      a      = vecs[i].a;
      b      = vecs[i].b;
      #1 check_comb($sformatf("vec%0d", i), vecs[i].out, vecs[i].flags);
    end
    @(posedge CLK);
    #1 check_reg("hold_in_reset", 32'd0, 4'b0000);

    // Release reset; the first capture comes on the next rising edge.
    @(negedge CLK);
    is_sub = 1'b0; a = 32'd312; b = 32'd1000;
    RST_N = 1'b1;
    #1 check_reg("pre_capture", 32'd0, 4'b0000);
    @(posedge CLK);
    #1 check_reg("capture1", 32'd1312, 4'b0000);
    is_sub = 1'b1;
    #1 check_comb("toggle_sub", 32'hFFFFFD50, 4'b0001);
    check_reg("latency_hold", 32'd1312, 4'b0000);
    @(posedge CLK);
    #1 check_reg("capture2", 32'hFFFFFD50, 4'b0001);

    // Mid-operation reset discards the registered value; comb outputs keep tracking.
    @(negedge CLK);
    RST_N = 1'b0;
    #1 check_reg("mid_reset", 32'd0, 4'b0000);
    a = 32'h7FFFFFFF; b = 32'd1; is_sub = 1'b0;
    #1 check_comb("comb_in_reset", 32'h80000000, 4'b0101);
    repeat (2) @(posedge CLK);
    #1 check_reg("mid_reset_hold", 32'd0, 4'b0000);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1 check_reg("resume", 32'h80000000, 4'b0101);

    // Randomized operands, biased toward corner values, through both paths.
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      is_sub = 1'($urandom);
      case ($urandom_range(0, 5))
        0: a = 32'h80000000;
        1: a = 32'h7FFFFFFF;
        2: a = 32'd0;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = a;
        1: b = 32'd1;
        2: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      model(is_sub, a, b, eo, ef);
      #1 check_comb($sformatf("rand%0d", i), eo, ef);
      @(posedge CLK);
      #1 check_reg($sformatf("rand%0d", i), eo, ef);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
